// File: rtl/code_decoder4b_fifo_if.sv
// Valid/ready handshake bundle for the code decoder FIFO: 2-bit codes in, one-hot lines out.
interface code_decoder4b_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;

  // master drives codes upstream and takes decoded lines downstream
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_onehot
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_onehot
  );
endinterface

// File: rtl/code_decoder4b_fifo.sv
// Buffers 2-bit encoded request codes in a small FIFO and re-expands the head entry
// into a one-hot line vector {a,b,c,d}, one dispatch per accepted output handshake.
module code_decoder4b_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  code_decoder4b_fifo_if.slave bus,
  output logic [CW-1:0]       count,
  output logic                overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;

  // Status is derived from the registered occupancy only
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));
  assign push_c  = bus.in_valid && !full_c;
  assign pop_c   = !empty_c && bus.out_ready;

  assign bus.in_ready   = !full_c;
  assign bus.out_valid  = !empty_c;
  // Gate on empty so stale memory never leaks onto the lines
  assign bus.out_onehot = empty_c ? 4'b0000 : 4'(4'b0001 << mem_q[rptr_q]);
  assign count          = count_q;
  assign overflow       = overflow_q;

  // Next-state: flush discards any push/pop but leaves the sticky overflow alone
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (bus.in_valid && full_c) begin
        overflow_d = 1'b1;
      end
      if (push_c) begin
        mem_d[wptr_q] = bus.in_code;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop_c) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: out_onehot is masked while empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule
